// File: rtl/ps2_kb_pkg.sv
// Shared types, scancode constants and the action decode table for the PS/2 key tracker.
// Covers scancode set 2 prefixes and the six game actions.
package ps2_kb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    SKIP
  } state_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_JUMP  = 8'h29;
  localparam logic [7:0] SC_START = 8'h5A;

  localparam logic [2:0] ACT_LEFT  = 3'd0;
  localparam logic [2:0] ACT_RIGHT = 3'd1;
  localparam logic [2:0] ACT_UP    = 3'd2;
  localparam logic [2:0] ACT_DOWN  = 3'd3;
  localparam logic [2:0] ACT_JUMP  = 3'd4;
  localparam logic [2:0] ACT_START = 3'd5;

  localparam int unsigned NUM_ACT = 6;

  // E1 is followed by seven more bytes in the make-only pause sequence.
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       brk;
    logic [2:0] act;
  } evt_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] act;
  } dec_t;

  function automatic dec_t decode_key(input logic [7:0] code, input logic ext);
    dec_t d;
    d.hit = 1'b1;
    d.act = ACT_LEFT;
    if (ext) begin
      case (code)
        SC_LEFT:  d.act = ACT_LEFT;
        SC_RIGHT: d.act = ACT_RIGHT;
        SC_UP:    d.act = ACT_UP;
        SC_DOWN:  d.act = ACT_DOWN;
        default:  d.hit = 1'b0;
      endcase
    end else begin
      case (code)
        SC_JUMP:  d.act = ACT_JUMP;
        SC_START: d.act = ACT_START;
        default:  d.hit = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO only lands if a pop
// happens in the same cycle. Read data reads as zero while empty.
module ps2_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == (AW + 1)'(DEPTH));
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    rdata   = empty ? '0 : mem_q[rd_q];

    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    // Depth is a power of two, so pointer overflow is the modulo wrap.
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// Turns the PS/2 set-2 byte stream into held-key state for six game actions and a
// deduplicated make/break event stream with a sticky overflow flag.
module ps2_key_tracker
  import ps2_kb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       key_press,
  input  logic [7:0] CODEWORD,
  input  logic       evt_ready,
  input  logic       ovf_clr,
  output logic [5:0] held,
  output logic       evt_valid,
  output logic [3:0] evt_data,
  output logic       overflow
);

  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [2:0]  skip_q, skip_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]  held_q, held_d;
  logic        ovf_q, ovf_d;

  logic        dec_en, dec_ext, dec_brk;
  dec_t        dec;
  evt_t        evt_in;
  logic        push, pop, drop;
  logic        fifo_full, fifo_empty;
  logic [3:0]  fifo_rdata;

  // Prefix FSM and timeout; only key_press cycles advance it, except the timeout.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    timer_d = timer_q;
    dec_en  = 1'b0;
    dec_ext = 1'b0;
    dec_brk = 1'b0;

    if (key_press) begin
      timer_d = '0;
      case (state_q)
        IDLE: begin
          if (CODEWORD == SC_EXT) begin
            state_d = EXT;
          end else if (CODEWORD == SC_BRK) begin
            state_d = BRK;
          end else if (CODEWORD == SC_PAUSE) begin
            state_d = SKIP;
            skip_d  = PAUSE_SKIP;
          end else begin
            dec_en = 1'b1;
          end
        end
        EXT: begin
          if (CODEWORD == SC_BRK) begin
            state_d = EXT_BRK;
          end else if (CODEWORD != SC_EXT) begin
            dec_en  = 1'b1;
            dec_ext = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          dec_en  = 1'b1;
          dec_brk = 1'b1;
          state_d = IDLE;
        end
        EXT_BRK: begin
          dec_en  = 1'b1;
          dec_ext = 1'b1;
          dec_brk = 1'b1;
          state_d = IDLE;
        end
        SKIP: begin
          skip_d = skip_q - 1'b1;
          if (skip_q == 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (timer_q == TIMER_LAST) begin
        state_d = IDLE;
        timer_d = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else begin
      timer_d = '0;
    end
  end

  // Held-state update and event generation; repeats and stray breaks are swallowed.
  always_comb begin
    dec        = decode_key(CODEWORD, dec_ext);
    held_d     = held_q;
    push       = 1'b0;
    evt_in.brk = dec_brk;
    evt_in.act = dec.act;
    if (dec_en && dec.hit) begin
      if (!dec_brk && !held_q[dec.act]) begin
        held_d[dec.act] = 1'b1;
        push            = 1'b1;
      end else if (dec_brk && held_q[dec.act]) begin
        held_d[dec.act] = 1'b0;
        push            = 1'b1;
      end
    end
  end

  always_comb begin
    pop   = ~fifo_empty & evt_ready;
    drop  = push & fifo_full & ~pop;
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      skip_q  <= '0;
      timer_q <= '0;
      held_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      timer_q <= timer_d;
      held_q  <= held_d;
      ovf_q   <= ovf_d;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(evt_t))
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (evt_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign held      = held_q;
  assign evt_valid = ~fifo_empty;
  assign evt_data  = fifo_rdata;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed scenarios plus random byte streams, checked every
// cycle against a sequence-level model of keys, event queue and overflow flag.
module tb_ps2_key_tracker;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TO    = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       key_press = 1'b0;
  logic [7:0] CODEWORD = 8'h00;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [5:0] held;
  logic       evt_valid;
  logic [3:0] evt_data;
  logic       overflow;

  ps2_key_tracker #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .key_press (key_press),
    .CODEWORD  (CODEWORD),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .held      (held),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .overflow  (overflow)
  );

  always #5 CLK = ~CLK;

  int compared = 0;
  int mismatched = 0;

  // Model: held keys, queued events, overflow flag, bytes of the unfinished sequence.
  logic [5:0] m_held;
  logic       m_ovf;
  logic [3:0] m_q[$];
  logic [7:0] seq[$];
  int         idle_cnt;
  logic       ev_push;
  logic [3:0] ev_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int act_of(input logic [7:0] c, input bit ext);
    if (ext) begin
      case (c)
        8'h6B: return 0;
        8'h74: return 1;
        8'h75: return 2;
        8'h72: return 3;
        default: return -1;
      endcase
    end
    case (c)
      8'h29: return 4;
      8'h5A: return 5;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_held = '0;
    m_ovf = 1'b0;
    m_q.delete();
    seq.delete();
    idle_cnt = 0;
  endtask

  // A sequence ends on a non-prefix byte, or on any byte following an F0.
  task automatic model_byte(input logic [7:0] b);
    bit complete, brk, ext;
    int a;
    seq.push_back(b);
    if (seq[0] == 8'hE1) begin
      if (seq.size() == 8) seq.delete();
      return;
    end
    brk = 1'b0;
    for (int i = 0; i < seq.size() - 1; i++) if (seq[i] == 8'hF0) brk = 1'b1;
    complete = brk || !(b == 8'hE0 || b == 8'hF0);
    if (!complete) return;
    ext = (seq[0] == 8'hE0);
    a = act_of(b, ext);
    seq.delete();
    if (a < 0) return;
    if (brk == m_held[a]) begin
      m_held[a] = ~brk;
      ev_push = 1'b1;
      ev_data = {brk, 3'(a)};
    end
  endtask

  task automatic tick(input logic kp, input logic [7:0] b, input logic rdy, input logic clr);
    bit pop, drop;
    key_press = kp;
    CODEWORD  = b;
    evt_ready = rdy;
    ovf_clr   = clr;
    @(negedge CLK);
    check("held", 32'(held), 32'(m_held));
    check("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
    check("evt_data", 32'(evt_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
    check("overflow", 32'(overflow), 32'(m_ovf));
    pop = rdy && (m_q.size() > 0);
    ev_push = 1'b0;
    drop = 1'b0;
    if (kp) begin
      idle_cnt = 0;
      model_byte(b);
    end else begin
      idle_cnt++;
      if (idle_cnt >= TO) seq.delete();
    end
    if (pop) void'(m_q.pop_front());
    if (ev_push) begin
      if (m_q.size() < DEPTH) m_q.push_back(ev_data);
      else drop = 1'b1;
    end
    if (clr) m_ovf = 1'b0;
    if (drop) m_ovf = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic rdy);
    tick(1'b1, b, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic do_reset();
    key_press = 1'b0;
    evt_ready = 1'b0;
    ovf_clr = 1'b0;
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check("rst_held", 32'(held), 32'h0);
    check("rst_valid", 32'(evt_valid), 32'h0);
    check("rst_data", 32'(evt_data), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  logic [7:0] pool [12];

  initial begin
    pool = '{8'hE0, 8'hF0, 8'hE1, 8'h6B, 8'h74, 8'h75, 8'h72, 8'h29, 8'h5A, 8'h14, 8'h77, 8'h00};
    model_reset();
    @(posedge CLK);
    #1;
    do_reset();

    // 1) JUMP make then break with the consumer always ready.
    send(8'h29, 1'b1);
    check("t1_held_make", 32'(held), 32'h10);
    check("t1_evt_make", 32'(evt_data), 32'h4);
    idle(1, 1'b1);
    send(8'hF0, 1'b1);
    send(8'h29, 1'b1);
    check("t1_held_brk", 32'(held), 32'h00);
    check("t1_evt_brk", 32'(evt_data), 32'hC);
    idle(2, 1'b1);

    // 2) Typematic repeats of LEFT produce one make, then one break.
    for (int i = 0; i < 3; i++) begin
      send(8'hE0, 1'b1);
      send(8'h6B, 1'b1);
      check("t2_held_rep", 32'(held), 32'h01);
    end
    send(8'hE0, 1'b1);
    send(8'hF0, 1'b1);
    send(8'h6B, 1'b1);
    idle(2, 1'b1);
    check("t2_held_end", 32'(held), 32'h00);

    // 3) Five makes into a four-deep FIFO with no consumer.
    do_reset();
    send(8'h29, 1'b0);
    send(8'h5A, 1'b0);
    send(8'hE0, 1'b0); send(8'h6B, 1'b0);
    send(8'hE0, 1'b0); send(8'h74, 1'b0);
    send(8'hE0, 1'b0); send(8'h75, 1'b0);
    idle(1, 1'b0);
    check("t3_held", 32'(held), 32'h37);
    check("t3_ovf", 32'(overflow), 32'h1);
    check("t3_head", 32'(evt_data), 32'h4);
    idle(5, 1'b1);
    check("t3_drained", 32'(evt_valid), 32'h0);
    tick(1'b0, 8'h00, 1'b0, 1'b1);
    idle(1, 1'b0);
    check("t3_ovf_clr", 32'(overflow), 32'h0);

    // 4) Pause sequence is discarded entirely.
    do_reset();
    send(8'hE1, 1'b0); send(8'h14, 1'b0); send(8'h77, 1'b0); send(8'hE1, 1'b0);
    send(8'hF0, 1'b0); send(8'h14, 1'b0); send(8'hF0, 1'b0); send(8'h77, 1'b0);
    send(8'h5A, 1'b0);
    check("t4_evt", 32'(evt_data), 32'h5);
    idle(1, 1'b1);
    idle(1, 1'b1);

    // 5) A stale E0 prefix times out before the next byte.
    do_reset();
    send(8'hE0, 1'b1);
    idle(TO + 2, 1'b1);
    send(8'h29, 1'b1);
    check("t5_jump", 32'(held), 32'h10);
    idle(2, 1'b1);

    // 6) Reset in the middle of E0 F0 discards the prefix.
    send(8'hE0, 1'b1);
    send(8'hF0, 1'b1);
    do_reset();
    send(8'h6B, 1'b1);
    idle(2, 1'b1);
    check("t6_held", 32'(held), 32'h00);
    check("t6_valid", 32'(evt_valid), 32'h0);

    // Random byte streams with random gaps, back-pressure and overflow clears.
    for (int n = 0; n < 1500; n++) begin
      int gap;
      send(pool[$urandom_range(11)], 1'($urandom_range(9) < 6));
      gap = ($urandom_range(49) == 0) ? int'(TO + $urandom_range(3)) : int'($urandom_range(2));
      for (int g = 0; g < gap; g++)
        tick(1'b0, 8'($urandom), 1'($urandom_range(9) < 6), 1'($urandom_range(19) == 0));
    end
    idle(8, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
